// File: rtl/draw_queue_if.sv
// -----------------------------------------------------------------------------
// draw_queue_if
// Bundles the two handshakes around draw_queue:
//   cmd side : cmd_valid/cmd_ready with cmd_id, cmd_x, cmd_y (game logic -> queue)
//   draw side: draw_start/draw_done level handshake with draw_id, draw_x, draw_y
//              (queue -> ROM sprite draw engine)
// Handshake semantics:
//   A command transfers on a rising clk edge where cmd_valid & cmd_ready are both
//   high. cmd_ready is decoded only from registered state, so a producer may look
//   at it before deciding to raise cmd_valid. On the draw side draw_start is a
//   level held high (with stable draw_id/x/y) until the engine answers with
//   draw_done high; draw_start then drops and the queue waits for draw_done low.
// Modports:
//   slave  - the queue (consumes commands, drives the draw engine)
//   master - the environment (game logic + draw engine)
// -----------------------------------------------------------------------------
interface draw_queue_if #(
  parameter int X_WIDTH  = 8,
  parameter int Y_WIDTH  = 7,
  parameter int ID_WIDTH = 4
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [ID_WIDTH-1:0] cmd_id;
  logic [X_WIDTH-1:0]  cmd_x;
  logic [Y_WIDTH-1:0]  cmd_y;

  logic                draw_start;
  logic [ID_WIDTH-1:0] draw_id;
  logic [X_WIDTH-1:0]  draw_x;
  logic [Y_WIDTH-1:0]  draw_y;
  logic                draw_done;

  modport slave (
    input  cmd_valid, cmd_id, cmd_x, cmd_y, draw_done,
    output cmd_ready, draw_start, draw_id, draw_x, draw_y
  );

  modport master (
    output cmd_valid, cmd_id, cmd_x, cmd_y, draw_done,
    input  cmd_ready, draw_start, draw_id, draw_x, draw_y
  );
endinterface

// File: rtl/draw_queue.sv
// -----------------------------------------------------------------------------
// draw_queue
// Command FIFO and sequencer in front of the ROM sprite draw engine. Game logic
// posts sprite draw requests (id + top-left x/y) in bursts; the queue issues
// them one at a time over the draw_start/draw_done level handshake.
//
// Ports:
//   clk, resetn  - clock, synchronous active-low reset
//   frame_tick   - (DRAW_QUEUE_FRAME_SYNC_EN only) one-cycle pulse per frame
//   bus          - draw_queue_if.slave: cmd_* push side, draw_* engine side
//   busy         - FSM not idle or queue non-empty
//   count        - entries queued, not counting the one in flight
//   err_drop     - sticky: an out-of-range command was discarded
//   state_dbg    - current FSM state encoding
//
// Optional feature macro: DRAW_QUEUE_FRAME_SYNC_EN. When defined, the first
// command of a batch (queue drained from empty) waits in WAIT_FRAME for
// frame_tick before issuing; commands following a RELEASE issue immediately.
// -----------------------------------------------------------------------------
module draw_queue #(
  parameter int X_WIDTH  = 8,
  parameter int X_MAX    = 160,
  parameter int Y_WIDTH  = 7,
  parameter int Y_MAX    = 120,
  parameter int ID_WIDTH = 4,
  parameter int DEPTH    = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
`ifdef DRAW_QUEUE_FRAME_SYNC_EN
  input  logic                     frame_tick,
`endif
  draw_queue_if.slave              bus,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err_drop,
  output logic [1:0]               state_dbg
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_RELEASE = 2'd2
`ifdef DRAW_QUEUE_FRAME_SYNC_EN
    , S_WAIT_FRAME = 2'd3
`endif
  } state_t;

  state_t              state_q, state_d;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic                start_q, start_d;
  logic [ID_WIDTH-1:0] id_q, id_d;
  logic [X_WIDTH-1:0]  x_q, x_d;
  logic [Y_WIDTH-1:0]  y_q, y_d;
  logic                first_q, first_d;
  logic                err_q, err_d;
`ifdef DRAW_QUEUE_FRAME_SYNC_EN
  logic                skip_q, skip_d;
`endif

  logic [ID_WIDTH-1:0] id_mem [DEPTH];
  logic [X_WIDTH-1:0]  x_mem  [DEPTH];
  logic [Y_WIDTH-1:0]  y_mem  [DEPTH];

  logic cmd_ready_w, in_range, accept, push, pop;

  // Ready comes from the registered count only: a pop in the same cycle never
  // frees a slot for a push while full.
  assign cmd_ready_w = (count_q != CW'(DEPTH));
  // Compare one bit wider so X_MAX/Y_MAX equal to 2**WIDTH still work.
  assign in_range = ({1'b0, bus.cmd_x} < (X_WIDTH+1)'(X_MAX)) &&
                    ({1'b0, bus.cmd_y} < (Y_WIDTH+1)'(Y_MAX));
  assign accept   = bus.cmd_valid & cmd_ready_w;
  assign push     = accept & in_range;

  always_comb begin
    state_d = state_q;
    start_d = start_q;
    id_d    = id_q;
    x_d     = x_q;
    y_d     = y_q;
    first_d = 1'b0;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
`ifdef DRAW_QUEUE_FRAME_SYNC_EN
          if (skip_q) pop = 1'b1;
          else        state_d = S_WAIT_FRAME;
`else
          pop = 1'b1;
`endif
        end
      end
`ifdef DRAW_QUEUE_FRAME_SYNC_EN
      S_WAIT_FRAME: begin
        if (frame_tick) pop = 1'b1;
      end
`endif
      S_ISSUE: begin
        // A draw_done still high from the previous draw is not trusted during
        // the first ISSUE cycle.
        if (!first_q && bus.draw_done) begin
          state_d = S_RELEASE;
          start_d = 1'b0;
        end
      end
      S_RELEASE: begin
        if (!bus.draw_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (pop) begin
      state_d = S_ISSUE;
      start_d = 1'b1;
      first_d = 1'b1;
      id_d    = id_mem[rd_ptr_q];
      x_d     = x_mem[rd_ptr_q];
      y_d     = y_mem[rd_ptr_q];
    end

    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    err_d = err_q | (accept & ~in_range);
`ifdef DRAW_QUEUE_FRAME_SYNC_EN
    // Set while in RELEASE so the IDLE cycle right after a draw may issue
    // without a frame tick; consumed by that IDLE cycle.
    skip_d = (state_q == S_RELEASE);
`endif
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      start_q  <= 1'b0;
      id_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      first_q  <= 1'b0;
      err_q    <= 1'b0;
`ifdef DRAW_QUEUE_FRAME_SYNC_EN
      skip_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      start_q  <= start_d;
      id_q     <= id_d;
      x_q      <= x_d;
      y_q      <= y_d;
      first_q  <= first_d;
      err_q    <= err_d;
`ifdef DRAW_QUEUE_FRAME_SYNC_EN
      skip_q   <= skip_d;
`endif
    end
  end

  // Storage needs no reset: entries are only read when count says they exist.
  always_ff @(posedge clk) begin
    if (push) begin
      id_mem[wr_ptr_q] <= bus.cmd_id;
      x_mem[wr_ptr_q]  <= bus.cmd_x;
      y_mem[wr_ptr_q]  <= bus.cmd_y;
    end
  end

  assign bus.cmd_ready  = cmd_ready_w;
  assign bus.draw_start = start_q;
  assign bus.draw_id    = id_q;
  assign bus.draw_x     = x_q;
  assign bus.draw_y     = y_q;
  assign busy           = (state_q != S_IDLE) || (count_q != '0);
  assign count          = count_q;
  assign err_drop       = err_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_draw_queue.sv
// -----------------------------------------------------------------------------
// tb_draw_queue
// Self-checking bench for draw_queue. Accepted in-range commands are pushed to
// an expected queue; a small draw-engine model pops and compares each issued
// draw, answers with draw_done after a set latency and checks the low gap
// between draws. Directed sections cover latency, stale done, fill/backpressure,
// ordering, range drops, reset mid-draw and (with the macro) frame sync.
// -----------------------------------------------------------------------------
module tb_draw_queue;

  localparam int W = 19;  // {id[3:0], x[7:0], y[6:0]}
`ifdef DRAW_QUEUE_FRAME_SYNC_EN
  localparam int FS_LAT = 1;
`else
  localparam int FS_LAT = 0;
`endif

  // clock / reset
  logic clk;
  logic resetn;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  draw_queue_if #(.X_WIDTH(8), .Y_WIDTH(7), .ID_WIDTH(4)) bus ();

  logic       busy;
  logic [3:0] count;
  logic       err_drop;
  logic [1:0] state_dbg;
`ifdef DRAW_QUEUE_FRAME_SYNC_EN
  logic       frame_tick;
`endif

  draw_queue #(
    .X_WIDTH(8), .X_MAX(160), .Y_WIDTH(7), .Y_MAX(120), .ID_WIDTH(4), .DEPTH(8)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
`ifdef DRAW_QUEUE_FRAME_SYNC_EN
    .frame_tick(frame_tick),
`endif
    .bus       (bus),
    .busy      (busy),
    .count     (count),
    .err_drop  (err_drop),
    .state_dbg (state_dbg)
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // draw engine model
  logic eng_en   = 1'b0;
  logic eng_done = 1'b0;
  logic man_done = 1'b0;
  int   eng_lat  = 4;
  int   eng_phase = 0;
  int   eng_cnt  = 0;
  assign bus.draw_done = eng_en ? eng_done : man_done;

  initial begin
    logic [W-1:0] e;
    forever begin
      @(posedge clk); #1;
      if (!eng_en) begin
        eng_phase = 0;
        eng_done  = 1'b0;
      end else begin
        case (eng_phase)
          0: if (bus.draw_start) begin
               if (exp_q.size() == 0) check("draw_unexpected", 1, 0);
               else begin
                 e = exp_q.pop_front();
                 check("draw_cmd", {bus.draw_id, bus.draw_x, bus.draw_y}, e);
               end
               eng_cnt   = eng_lat;
               eng_phase = 1;
             end
          1: begin
               eng_cnt--;
               if (eng_cnt == 0) begin
                 eng_done  = 1'b1;
                 eng_phase = 2;
               end
             end
          2: if (!bus.draw_start) begin
               eng_done  = 1'b0;
               eng_phase = 3;
             end
          default: begin
               check("gap_low", bus.draw_start, 0);
               eng_phase = 0;
             end
        endcase
      end
    end
  end

  // driver tasks
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    eng_en   = 1'b0;
    man_done = 1'b0;
    resetn   = 1'b0;
    cyc(1);
    resetn   = 1'b1;
    exp_q.delete();
  endtask

  // Leaves cmd_valid high so callers can push back-to-back.
  task automatic push_cmd(input logic [3:0] id, input logic [7:0] x, input logic [6:0] y);
    logic rdy;
    bit   ok;
    ok = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_id = id;
    bus.cmd_x  = x;
    bus.cmd_y  = y;
    for (int i = 0; i < 200 && !ok; i++) begin
      rdy = bus.cmd_ready;
      cyc(1);
      if (rdy) ok = 1'b1;
    end
    if (!ok) check("push_timeout", 0, 1);
    else if (x < 8'd160 && y < 7'd120) exp_q.push_back({id, x, y});
  endtask

  task automatic wait_drain(input int bound);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      cyc(1);
      if (exp_q.size() == 0 && !busy && eng_phase == 0 && !bus.draw_done) ok = 1'b1;
    end
    check("drain_done", ok, 1);
    check("drain_count", count, 0);
  endtask

  initial begin
    resetn = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_id = '0;
    bus.cmd_x  = '0;
    bus.cmd_y  = '0;
`ifdef DRAW_QUEUE_FRAME_SYNC_EN
    frame_tick = 1'b1;
`endif
    cyc(2);
    do_reset();

    // reset values
    check("rst_start", bus.draw_start, 0);
    check("rst_cmd", {bus.draw_id, bus.draw_x, bus.draw_y}, 0);
    check("rst_err", err_drop, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", bus.cmd_ready, 1);
    check("rst_count", count, 0);

    // single command, latency and release
    push_cmd(4'd3, 8'd10, 7'd20);
    bus.cmd_valid = 1'b0;
    check("single_count", count, 1);
    check("single_early", bus.draw_start, 0);
    cyc(1 + FS_LAT);
    check("single_start", bus.draw_start, 1);
    check("single_cmd", {bus.draw_id, bus.draw_x, bus.draw_y}, {4'd3, 8'd10, 7'd20});
    check("single_count0", count, 0);
    check("single_busy", busy, 1);
    cyc(4);
    check("single_hold", bus.draw_start, 1);
    man_done = 1'b1;
    cyc(1);
    check("single_release", bus.draw_start, 0);
    check("single_busy_rel", busy, 1);
    man_done = 1'b0;
    cyc(1);
    check("single_idle", busy, 0);
    check("single_state", state_dbg, 0);
    exp_q.delete();

    // stale draw_done ignored on the first ISSUE cycle
    man_done = 1'b1;
    push_cmd(4'd5, 8'd1, 7'd2);
    bus.cmd_valid = 1'b0;
    cyc(1 + FS_LAT);
    check("stale_start", bus.draw_start, 1);
    cyc(1);
    check("stale_ignore", bus.draw_start, 1);
    cyc(1);
    check("stale_release", bus.draw_start, 0);
    man_done = 1'b0;
    cyc(1);
    check("stale_idle", busy, 0);
    exp_q.delete();

    // fill: one in flight plus DEPTH queued, then backpressure
    for (int i = 0; i < 9; i++)
      push_cmd(4'(i + 1), 8'(i * 3), 7'(i * 2));
    check("fill_count", count, 8);
    check("fill_ready", bus.cmd_ready, 0);
    check("fill_inflight", bus.draw_start, 1);
    eng_lat = 3;
    eng_en  = 1'b1;
    push_cmd(4'd10, 8'd159, 7'd119);
    bus.cmd_valid = 1'b0;
    wait_drain(600);

    // ordering with random-ish coordinates
    eng_lat = 4;
    for (int i = 1; i <= 3; i++)
      push_cmd(4'(i), 8'($urandom_range(0, 159)), 7'($urandom_range(0, 119)));
    bus.cmd_valid = 1'b0;
    wait_drain(300);

    // out-of-range commands are consumed and dropped
    push_cmd(4'd7, 8'd160, 7'd0);
    push_cmd(4'd7, 8'd0, 7'd120);
    bus.cmd_valid = 1'b0;
    cyc(2);
    check("range_count", count, 0);
    check("range_err", err_drop, 1);
    check("range_start", bus.draw_start, 0);
    check("range_busy", busy, 0);
    push_cmd(4'd8, 8'd40, 7'd50);
    bus.cmd_valid = 1'b0;
    wait_drain(200);
    check("range_sticky", err_drop, 1);

    // reset mid-draw
    eng_en = 1'b0;
    for (int i = 0; i < 4; i++)
      push_cmd(4'(i + 11), 8'(i), 7'(i));
    bus.cmd_valid = 1'b0;
    check("mid_count", count, 3);
    check("mid_start", bus.draw_start, 1);
    do_reset();
    check("mid_rst_start", bus.draw_start, 0);
    check("mid_rst_count", count, 0);
    check("mid_rst_err", err_drop, 0);
    check("mid_rst_ready", bus.cmd_ready, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_cmd", {bus.draw_id, bus.draw_x, bus.draw_y}, 0);

`ifdef DRAW_QUEUE_FRAME_SYNC_EN
    // first command waits for a tick; the second follows without one
    frame_tick = 1'b0;
    eng_lat = 4;
    eng_en  = 1'b1;
    push_cmd(4'd1, 8'd20, 7'd30);
    push_cmd(4'd2, 8'd21, 7'd31);
    bus.cmd_valid = 1'b0;
    cyc(10);
    check("fs_wait_start", bus.draw_start, 0);
    check("fs_wait_busy", busy, 1);
    check("fs_wait_state", state_dbg, 3);
    frame_tick = 1'b1;
    cyc(1);
    frame_tick = 1'b0;
    check("fs_start", bus.draw_start, 1);
    wait_drain(200);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
